// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter / fetch sequencer for one program run.
// Drives the branch-target LUT index, takes the absolute target back the
// same cycle, and steps the PC by increment or branch until DONE_PC.
// Out-of-range next addresses park the block in FAULT with the PC held.
// Per-run counters report RUN cycles and retired (advanced) instructions.
module pc_fetch_ctrl #(
    parameter int D          = 12,
    parameter int START_PC   = 0,
    parameter int DONE_PC    = 71,
    parameter int IMEM_DEPTH = 1024,
    parameter int CW         = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic          stall,
    input  logic          branch_en,
    input  logic [4:0]    branch_idx,
    output logic [4:0]    lut_addr,
    input  logic [D-1:0]  lut_target,
    output logic [D-1:0]  prog_counter,
    output logic          running,
    output logic          done,
    output logic          fault,
    output logic [CW-1:0] cycle_count,
    output logic [CW-1:0] retired_count
);

    localparam logic [D-1:0] START_PC_V = D'(START_PC);
    localparam logic [D-1:0] DONE_PC_V  = D'(DONE_PC);
    localparam logic [31:0]  IMEM_LIM   = 32'(IMEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [D-1:0]    r_pc;
    logic [D-1:0]    w_pc_next;
    logic [CW-1:0]   r_cyc;
    logic [CW-1:0]   w_cyc_next;
    logic [CW-1:0]   r_ret;
    logic [CW-1:0]   w_ret_next;

    logic [D:0]      w_pc_inc;
    logic            w_inc_oob;
    logic            w_tgt_oob;
    logic [CW-1:0]   w_cyc_sat;
    logic [CW-1:0]   w_ret_sat;

    // The LUT index is a straight pass-through of the instruction field.
    assign lut_addr = branch_idx;

    // One extra bit on the increment catches wrap at 2^D as well as depth overrun.
    assign w_pc_inc  = {1'b0, r_pc} + {{D{1'b0}}, 1'b1};
    assign w_inc_oob = w_pc_inc[D] | (32'(w_pc_inc) >= IMEM_LIM);
    assign w_tgt_oob = (32'(lut_target) >= IMEM_LIM);

    // Saturating +1 for both counters; they stick at all-ones.
    assign w_cyc_sat = (&r_cyc) ? r_cyc : r_cyc + {{(CW-1){1'b0}}, 1'b1};
    assign w_ret_sat = (&r_ret) ? r_ret : r_ret + {{(CW-1){1'b0}}, 1'b1};

    // State, PC and counter registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= START_PC_V;
            r_cyc   <= '0;
            r_ret   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_cyc   <= w_cyc_next;
            r_ret   <= w_ret_next;
        end
    end

    // Next-state and datapath: stall > done-check > branch > increment in RUN.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_cyc_next   = r_cyc;
        w_ret_next   = r_ret;
        case (r_state)
            S_RUN: begin
                if (stall) begin
                    w_cyc_next = w_cyc_sat;
                end else if (r_pc == DONE_PC_V) begin
                    w_state_next = S_DONE;
                end else if (branch_en) begin
                    if (w_tgt_oob) begin
                        w_state_next = S_FAULT;
                    end else begin
                        w_pc_next  = lut_target;
                        w_cyc_next = w_cyc_sat;
                        w_ret_next = w_ret_sat;
                    end
                end else begin
                    if (w_inc_oob) begin
                        w_state_next = S_FAULT;
                    end else begin
                        w_pc_next  = w_pc_inc[D-1:0];
                        w_cyc_next = w_cyc_sat;
                        w_ret_next = w_ret_sat;
                    end
                end
            end
            default: begin
                // IDLE, DONE and FAULT all hold until a start pulse.
                if (start) begin
                    w_state_next = S_RUN;
                    w_pc_next    = START_PC_V;
                    w_cyc_next   = '0;
                    w_ret_next   = '0;
                end
            end
        endcase
    end

    // Status flags decode straight from the state register.
    assign running       = (r_state == S_RUN);
    assign done          = (r_state == S_DONE);
    assign fault         = (r_state == S_FAULT);
    assign prog_counter  = r_pc;
    assign cycle_count   = r_cyc;
    assign retired_count = r_ret;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch sequencer that sits directly upstream of the instruction memory.
- Consumes the branch-target lookup: drives the 5-bit LUT index and takes the D-bit absolute target back combinationally.
- Sequences one program run: start, increment or branch each cycle, stop at the done address.
- Also flags out-of-range targets and reports per-run cycle and retired-instruction counts.

Parameters:
- D, 12, PC width in bits; must equal the target-LUT width.
- START_PC, 0, PC loaded on each start.
- DONE_PC, 71, PC value that ends a run.
- IMEM_DEPTH, 1024, number of valid instruction addresses; a PC at or above this is a fault.
- CW, 16, width of both counters.

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse that begins a run; only honoured in IDLE, DONE or FAULT
- stall  in  1  hold PC this cycle
- branch_en  in  1  taken branch for the instruction at prog_counter
- branch_idx  in  5  LUT index from the instruction field
- lut_addr  out  5  index to the target LUT; equals branch_idx combinationally
- lut_target  in  D  absolute target returned by the LUT, same cycle
- prog_counter  out  D  current fetch address (registered)
- running  out  1  high in RUN
- done  out  1  high in DONE
- fault  out  1  high in FAULT
- cycle_count  out  CW  cycles spent in RUN during the current or last run
- retired_count  out  CW  non-stalled RUN cycles, i.e. instructions advanced

Behaviour:
- Reset (Reset_n low, asynchronous, any state including mid-run):
  - State goes to IDLE.
  - prog_counter=START_PC, done=0, running=0, fault=0, cycle_count=0, retired_count=0.
- States: IDLE, RUN, DONE, FAULT.
  - running/done/fault are decoded from the state register, so they are glitch-free and registered.
- IDLE/DONE/FAULT with start=1:
  - Next cycle: RUN, prog_counter=START_PC, both counters cleared to 0.
  - With start=0 the block holds all values.
- RUN, evaluated each cycle with priority stall > done-check > branch > increment:
  - stall=1: PC held, retired_count held, cycle_count+1.
  - prog_counter==DONE_PC: next state DONE, PC held at DONE_PC, counters freeze (this cycle not counted as retired). branch_en is ignored on this cycle.
  - branch_en=1: next PC = lut_target. If lut_target >= IMEM_DEPTH, next state FAULT instead and PC holds its old value.
  - otherwise: next PC = PC+1. If PC+1 >= IMEM_DEPTH or it wraps at 2^D, next state FAULT and PC holds.
  - Every non-stalled RUN cycle that advances the PC increments both counters by 1.
- start while in RUN is ignored; no restart mid-run.
- Latency:
  - Branch: decision in cycle N, new PC visible in cycle N+1. No delay slot; PC_LUT is combinational, so no extra cycle.
  - Reaching DONE_PC: done asserts one cycle after prog_counter first equals DONE_PC.
- Counters saturate at 2^CW-1 and do not wrap. Saturation does not affect control flow.
- lut_addr is purely combinational from branch_idx. It carries no state and is valid in every state.
- A branch to DONE_PC is legal: the block enters DONE on the following cycle.
- A branch to the current PC (self-loop) is legal. It spins until stall or reset; no watchdog.

Test Plan:
- Reset mid-run: start, run 5 cycles, pull Reset_n low between clock edges -> state resets immediately (before the next edge): prog_counter=0, running=0, done=0, counters=0.
- Straight-line to done (DONE_PC=71, START_PC=0): pulse start, no branches -> prog_counter steps 0..71. done rises on the cycle after PC=71; retired_count=71, cycle_count=71. PC stays at 71 afterwards; a second start restarts at 0 with counters cleared.
- Branch with stall: at PC=3, branch_en=1, branch_idx=0, lut_target=20, stall=1 for 2 cycles, then stall=0 -> PC stays at 3 for 2 cycles, then becomes 20. cycle_count advances by 3, retired_count by 1.
- Branch to done: at PC=10, branch_en=1, branch_idx=1, lut_target=71 -> PC=71 next cycle, done the cycle after.
- Fault on bad target (IMEM_DEPTH=1024): branch with lut_target=1500 at PC=5 -> fault=1 and running=0 next cycle, PC stays 5. start then recovers to RUN at PC=0.
- Start ignored in RUN, and self-loop: pulse start at PC=30 -> no effect, PC=31 next. Then branch_en=1 with lut_target=40 at PC=40 -> PC holds at 40 while retired_count keeps incrementing.
